// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the two-port memory arbiter
//   slave  : arbiter side (samples requests and mem_rdata, drives grants, rdata and the memory)
//   master : requester/memory side (drives requests and mem_rdata)
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
        output rdata, mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
        input  rdata, mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter/sequencer sharing one 1-cycle-latency memory between two ports
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : requester ports p0/p1, shared rdata, memory port and busy (slave modport)
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;

    logic [1:0]    state_q, state_d;
    // owner doubles as last_owner: both are loaded with the winner on every win
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          win;
    logic          winner;

    always_comb begin
        win     = (state_q == IDLE) && (bus.p0_req || bus.p1_req);
        // under contention the port that did not win last time goes next
        winner  = (bus.p0_req && bus.p1_req) ? ~owner_q : bus.p1_req;
        state_d = win ? ISSUE : (state_q == ISSUE && !we_q) ? RDATA : IDLE;
        owner_d = win ? winner : owner_q;
        we_d    = win ? (winner ? bus.p1_we : bus.p0_we) : we_q;
        addr_d  = win ? (winner ? bus.p1_addr : bus.p0_addr) : addr_q;
        wdata_d = win ? (winner ? bus.p1_wdata : bus.p0_wdata) : wdata_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // latched address/data feed the memory directly, so they hold outside ISSUE
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    assign bus.p0_gnt    = (state_q == ISSUE) && !owner_q;
    assign bus.p1_gnt    = (state_q == ISSUE) && owner_q;
    assign bus.p0_rvalid = (state_q == RDATA) && !owner_q;
    assign bus.p1_rvalid = (state_q == RDATA) && owner_q;
    assign bus.rdata     = (state_q == RDATA) ? bus.mem_rdata : '0;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int n_pass = 0;
    int n_chk = 0;
    logic [31:0] ref_mem [0:255];
    logic [31:0] mem [0:255];

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
    mem_port_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        return (a == 16) ? 32'hDEADBEEF : (32'hC0DE0000 ^ (32'(a) * 32'h01010101));
    endfunction

    // synchronous memory with one-cycle registered read
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic req_port(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        if (p) begin
            bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
        end else begin
            bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_port(1'b0, 1'b0, 32'h8, 32'h0);
        req_port(1'b1, 1'b0, 32'h9, 32'h0);
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.mem_we, bus.busy} !== 6'b0)
            $display("FAIL reset_ctl: got %b want 000000", {bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.mem_we, bus.busy});
        else n_pass++;
        n_chk++;
        if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 96'b0)
            $display("FAIL reset_data: got %h %h %h want zeros", bus.mem_addr, bus.mem_wdata, bus.rdata);
        else n_pass++;
        resetn = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) $display("FAIL reset_first_grant: got %b want 10", {bus.p0_gnt, bus.p1_gnt});
        else n_pass++;
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.p0_rvalid !== 1'b1 || bus.rdata !== ref_mem[8])
            $display("FAIL reset_first_read: got rv=%b %h want rv=1 %h", bus.p0_rvalid, bus.rdata, ref_mem[8]);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0) $display("FAIL reset_back_idle: got busy=%b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_single_read();
        req_port(1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        n_chk++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.mem_we, bus.busy} !== 4'b1001 || bus.mem_addr !== 32'h10)
            $display("FAIL read_issue: got gnt=%b%b we=%b busy=%b addr=%h want 1001 addr=10", bus.p0_gnt, bus.p1_gnt, bus.mem_we, bus.busy, bus.mem_addr);
        else n_pass++;
        bus.p0_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.p0_rvalid, bus.p1_rvalid, bus.p1_gnt} !== 3'b100 || bus.rdata !== 32'hDEADBEEF)
            $display("FAIL read_data: got rv=%b%b rdata=%h want 10 deadbeef", bus.p0_rvalid, bus.p1_rvalid, bus.rdata);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({bus.p0_rvalid, bus.busy} !== 2'b00) $display("FAIL read_done: got rv=%b busy=%b want 00", bus.p0_rvalid, bus.busy);
        else n_pass++;
    endtask

    task automatic test_single_write();
        req_port(1'b1, 1'b1, 32'h20, 32'h12345678);
        @(negedge clk);
        n_chk++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.mem_we} !== 3'b011 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h12345678)
            $display("FAIL write_issue: got gnt=%b%b we=%b %h %h want 011 20 12345678", bus.p0_gnt, bus.p1_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        ref_mem[8'h20] = 32'h12345678;
        bus.p1_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.mem_we, bus.p0_rvalid, bus.p1_rvalid} !== 4'b0 || bus.mem_addr !== 32'h20)
            $display("FAIL write_done: got busy=%b we=%b rv=%b%b addr=%h want 0000 addr=20", bus.busy, bus.mem_we, bus.p0_rvalid, bus.p1_rvalid, bus.mem_addr);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [31:0] a0 [4];
        logic [31:0] a1 [4];
        int i0 = 0, i1 = 0, g = 0, r = 0, cyc = 0;
        logic pend = 1'b0;
        logic [31:0] pend_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            a0[i] = 32'($urandom_range(0, 255));
            a1[i] = 32'($urandom_range(0, 255));
        end
        req_port(1'b0, 1'b0, a0[0], 32'h0);
        req_port(1'b1, 1'b0, a1[0], 32'h0);
        while (r < 8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.p0_gnt || bus.p1_gnt) begin
                n_chk++;
                if ({bus.p0_gnt, bus.p1_gnt} !== ((g % 2 == 0) ? 2'b10 : 2'b01))
                    $display("FAIL contention_order: grant %0d got %b want %b", g, {bus.p0_gnt, bus.p1_gnt}, (g % 2 == 0) ? 2'b10 : 2'b01);
                else n_pass++;
                pend = bus.p1_gnt;
                pend_addr = pend ? a1[i1 & 3] : a0[i0 & 3];
                n_chk++;
                if (bus.mem_addr !== pend_addr || bus.mem_we !== 1'b0)
                    $display("FAIL contention_addr: got %h we=%b want %h we=0", bus.mem_addr, bus.mem_we, pend_addr);
                else n_pass++;
                g++;
                if (pend) begin
                    i1++;
                    if (i1 < 4) bus.p1_addr = a1[i1]; else bus.p1_req = 1'b0;
                end else begin
                    i0++;
                    if (i0 < 4) bus.p0_addr = a0[i0]; else bus.p0_req = 1'b0;
                end
            end
            if (bus.p0_rvalid || bus.p1_rvalid) begin
                n_chk++;
                if ({bus.p0_rvalid, bus.p1_rvalid} !== (pend ? 2'b01 : 2'b10))
                    $display("FAIL contention_rvalid: got %b want %b", {bus.p0_rvalid, bus.p1_rvalid}, pend ? 2'b01 : 2'b10);
                else n_pass++;
                n_chk++;
                if (bus.rdata !== ref_mem[pend_addr[7:0]])
                    $display("FAIL contention_rdata: got %h want %h", bus.rdata, ref_mem[pend_addr[7:0]]);
                else n_pass++;
                r++;
            end
        end
        n_chk++;
        if (r != 8 || g != 8) $display("FAIL contention_count: got grants=%0d reads=%0d want 8 8", g, r);
        else n_pass++;
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_glitch();
        req_port(1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        n_chk++;
        if (bus.p0_gnt !== 1'b1 || bus.mem_addr !== 32'h40) $display("FAIL glitch_issue: got gnt=%b addr=%h want 1 40", bus.p0_gnt, bus.mem_addr);
        else n_pass++;
        bus.p0_req = 1'b0;
        bus.p0_addr = 32'h44;
        @(negedge clk);
        n_chk++;
        if (bus.p0_rvalid !== 1'b1 || bus.rdata !== ref_mem[8'h40] || bus.mem_addr !== 32'h40)
            $display("FAIL glitch_data: got rv=%b %h addr=%h want 1 %h 40", bus.p0_rvalid, bus.rdata, bus.mem_addr, ref_mem[8'h40]);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0) $display("FAIL glitch_idle: got busy=%b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_rdata();
        req_port(1'b0, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        bus.p0_req = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        n_chk++;
        if ({bus.p0_rvalid, bus.p1_rvalid, bus.busy, bus.mem_we} !== 4'b0 || bus.rdata !== 32'h0)
            $display("FAIL rst_rdata_abort: got rv=%b%b busy=%b we=%b rdata=%h want 0000 0", bus.p0_rvalid, bus.p1_rvalid, bus.busy, bus.mem_we, bus.rdata);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({bus.p0_rvalid, bus.busy} !== 2'b00) $display("FAIL rst_rdata_hold: got rv=%b busy=%b want 00", bus.p0_rvalid, bus.busy);
        else n_pass++;
        resetn = 1'b1;
        req_port(1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        n_chk++;
        if (bus.p0_gnt !== 1'b1 || bus.mem_addr !== 32'h10) $display("FAIL rst_rdata_regrant: got gnt=%b addr=%h want 1 10", bus.p0_gnt, bus.mem_addr);
        else n_pass++;
        bus.p0_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.p0_rvalid !== 1'b1 || bus.rdata !== ref_mem[8'h10])
            $display("FAIL rst_rdata_reread: got rv=%b %h want 1 %h", bus.p0_rvalid, bus.rdata, ref_mem[8'h10]);
        else n_pass++;
        @(negedge clk);
    endtask

    // transaction-level model: k counts the cycle inside the current transaction (0 = arbitrating)
    task automatic test_random();
        int k = 0;
        logic own = 1'b1, mwe = 1'b0;
        logic [31:0] maddr = 32'h0, mwd = 32'h0;
        logic [5:0] exp_ctl;
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            exp_ctl = {k == 1 && !own, k == 1 && own, k == 2 && !own, k == 2 && own, k == 1 && mwe, k != 0};
            n_chk++;
            if ({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.mem_we, bus.busy} !== exp_ctl)
                $display("FAIL random_ctl: cycle %0d got %b want %b", c, {bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.mem_we, bus.busy}, exp_ctl);
            else n_pass++;
            n_chk++;
            if ({bus.mem_addr, bus.mem_wdata} !== {maddr, mwd})
                $display("FAIL random_mem: cycle %0d got %h %h want %h %h", c, bus.mem_addr, bus.mem_wdata, maddr, mwd);
            else n_pass++;
            if (k == 2) begin
                n_chk++;
                if (bus.rdata !== ref_mem[maddr[7:0]]) $display("FAIL random_rdata: cycle %0d got %h want %h", c, bus.rdata, ref_mem[maddr[7:0]]);
                else n_pass++;
            end
            if (k == 1) begin
                if (own) bus.p1_req = 1'b0; else bus.p0_req = 1'b0;
            end
            if (c < 280) begin
                if (!bus.p0_req && $urandom_range(0, 2) == 0)
                    req_port(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
                if (!bus.p1_req && $urandom_range(0, 2) == 0)
                    req_port(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
            end
            if (k == 0) begin
                if (bus.p0_req || bus.p1_req) begin
                    own = (bus.p0_req && bus.p1_req) ? !own : bus.p1_req;
                    mwe = own ? bus.p1_we : bus.p0_we;
                    maddr = own ? bus.p1_addr : bus.p0_addr;
                    mwd = own ? bus.p1_wdata : bus.p0_wdata;
                    k = 1;
                end
            end else if (k == 1) begin
                if (mwe) ref_mem[maddr[7:0]] = mwd;
                k = mwe ? 0 : 2;
            end else begin
                k = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_glitch();
        test_reset_rdata();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
